// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
//
// Contents:
//   DIV_WIDTH_DEFAULT - default operand/result width
//   div_state_e       - controller states (IDLE, RUN, FIXUP, DONE)
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step.
// The step is purely combinational: shift in the next dividend bit,
// trial-subtract the divisor, and keep the difference only when the
// subtraction did not borrow.
//
// Ports:
//   i_rem     - partial remainder before this step (WIDTH+1 bits)
//   i_bit     - next dividend magnitude bit, MSB first
//   i_divisor - divisor magnitude (WIDTH+1 bits)
//   o_rem     - partial remainder after this step
//   o_qBit    - quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0] i_rem,
  input  logic           i_bit,
  input  logic [WIDTH:0] i_divisor,
  output logic [WIDTH:0] o_rem,
  output logic           o_qBit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // One extra bit above the shifted remainder acts as the borrow flag.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  assign o_qBit = ~w_diff[WIDTH+1];
  assign o_rem  = w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];

endmodule

// File: rtl/div_iter_32.sv
// Iterative signed divider (restoring, one quotient bit per clock).
// Operands are converted to magnitudes, divided over WIDTH cycles, then the
// quotient (and optionally the remainder) get their signs restored.
// The quotient truncates toward zero. Divide-by-zero and the single overflow
// case (most-negative / -1) raise data_exception.
//
// Optional feature: define DIV_ITER_REMAINDER_EN to add the data_remainder
// output (remainder carries the dividend's sign, A = Q*B + R).
//
// Ports:
//   clock          - rising-edge clock
//   reset_n        - asynchronous active-low reset
//   ctrl_div       - start strobe; restarts any operation in flight
//   data_operandA  - signed dividend, captured on start
//   data_operandB  - signed divisor, captured on start
//   data_result    - signed quotient, held until the next result
//   data_exception - divide-by-zero / overflow, valid with data_resultRDY
//   data_resultRDY - one-cycle pulse when a result is presented
//   data_remainder - signed remainder (DIV_ITER_REMAINDER_EN only)
module div_iter_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_ITER_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e r_state;
  div_state_e w_nextState;

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   r_divisor;
  logic             r_negQ;
  logic [WIDTH-1:0] r_qFix;
  logic             r_ovf;
`ifdef DIV_ITER_REMAINDER_EN
  logic             r_negR;
  logic [WIDTH-1:0] r_remFix;
`endif

  logic [WIDTH:0] w_aExt;
  logic [WIDTH:0] w_bExt;
  logic [WIDTH:0] w_aMag;
  logic [WIDTH:0] w_bMag;
  logic           w_bZero;
  logic [WIDTH:0] w_stepRem;
  logic           w_qBit;

  // Magnitudes are formed at WIDTH+1 bits so |most-negative| fits.
  assign w_aExt  = {data_operandA[WIDTH-1], data_operandA};
  assign w_bExt  = {data_operandB[WIDTH-1], data_operandB};
  assign w_aMag  = w_aExt[WIDTH] ? -w_aExt : w_aExt;
  assign w_bMag  = w_bExt[WIDTH] ? -w_bExt : w_bExt;
  assign w_bZero = (data_operandB == '0);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[WIDTH-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_stepRem),
    .o_qBit   (w_qBit)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state. A start strobe wins in every state, so a running
  // operation is abandoned without ever being signalled.
  always_comb begin
    w_nextState = r_state;
    if (ctrl_div) begin
      w_nextState = w_bZero ? DONE : RUN;
    end else begin
      case (r_state)
        IDLE:    w_nextState = IDLE;
        RUN:     if (r_count == LAST_STEP) w_nextState = FIXUP;
        FIXUP:   w_nextState = DONE;
        DONE:    w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Datapath. On start the dividend magnitude is loaded into the quotient
  // shift register; quotient bits enter at the bottom as dividend bits
  // leave from the top. The magnitude's top bit is always zero for a
  // WIDTH-bit operand, so it simply seeds the partial remainder.
  // Divide-by-zero preloads the fixed-up result so DONE can present it
  // the cycle after the start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count        <= '0;
      r_quo          <= '0;
      r_rem          <= '0;
      r_divisor      <= '0;
      r_negQ         <= 1'b0;
      r_qFix         <= '0;
      r_ovf          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_ITER_REMAINDER_EN
      r_negR         <= 1'b0;
      r_remFix       <= '0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_div) begin
        r_count   <= '0;
        r_quo     <= w_aMag[WIDTH-1:0];
        r_rem     <= {{WIDTH{1'b0}}, w_aMag[WIDTH]};
        r_divisor <= w_bMag;
        r_negQ    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef DIV_ITER_REMAINDER_EN
        r_negR    <= data_operandA[WIDTH-1];
`endif
        if (w_bZero) begin
          r_qFix   <= '0;
          r_ovf    <= 1'b1;
`ifdef DIV_ITER_REMAINDER_EN
          r_remFix <= '0;
`endif
        end
      end else begin
        case (r_state)
          RUN: begin
            r_rem   <= w_stepRem;
            r_quo   <= {r_quo[WIDTH-2:0], w_qBit};
            r_count <= r_count + CW'(1);
          end
          FIXUP: begin
            // Only a positive quotient of 2^(WIDTH-1) can overflow.
            r_qFix   <= r_negQ ? -r_quo : r_quo;
            r_ovf    <= ~r_negQ & r_quo[WIDTH-1];
`ifdef DIV_ITER_REMAINDER_EN
            r_remFix <= r_negR ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
`endif
          end
          DONE: begin
            data_result    <= r_qFix;
            data_exception <= r_ovf;
            data_resultRDY <= 1'b1;
`ifdef DIV_ITER_REMAINDER_EN
            data_remainder <= r_remFix;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter_32.sv
// Self-checking bench for div_iter_32 (default WIDTH = 32).
// Expected results come from a 64-bit arithmetic model and are queued
// when an operation is launched, then popped when data_resultRDY fires.
module tb_div_iter_32;

  localparam int RDY_LIMIT = 60;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIV_ITER_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] q;
    logic        exc;
    logic [31:0] r;
  } expect_t;

  expect_t scoreboard[$];

  div_iter_32 dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_div      (ctrl_div),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
`ifdef DIV_ITER_REMAINDER_EN
    ,
    .data_remainder(data_remainder)
`endif
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation timed out");
  end

  // One comparison: counts, and reports on mismatch.
  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: signed division in 64-bit arithmetic.
  function automatic expect_t model(input logic [31:0] a, input logic [31:0] b);
    expect_t m;
    longint  sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sbv == 0) begin
      m.q   = '0;
      m.exc = 1'b1;
      m.r   = '0;
    end else begin
      q     = sa / sbv;
      r     = sa - q * sbv;
      m.q   = q[31:0];
      m.r   = r[31:0];
      m.exc = (q > 64'sd2147483647);
    end
    return m;
  endfunction

  // Launch an operation: the start is sampled by the next rising edge
  // (edge 0). Returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit track);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_div      = 1'b1;
    if (track) scoreboard.push_back(model(a, b));
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
  endtask

  // Wait (bounded) for the RDY pulse, verify its edge number and the result.
  task automatic checkOutput(input int expEdge, input string tag);
    int      n;
    expect_t e;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!data_resultRDY && n < RDY_LIMIT);
    checkEq({tag, " rdy edge"}, n, expEdge);
    checkEq({tag, " scoreboard entry"}, (scoreboard.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    e = (scoreboard.size() > 0) ? scoreboard.pop_front() : '0;
    checkEq({tag, " result"}, data_result, e.q);
    checkEq({tag, " exception"}, {31'd0, data_exception}, {31'd0, e.exc});
`ifdef DIV_ITER_REMAINDER_EN
    checkEq({tag, " remainder"}, data_remainder, e.r);
`endif
    @(posedge clock);
    #1;
    checkEq({tag, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  // Watch a number of edges and require that RDY never fires.
  task automatic watchNoRdy(input int edges, input string tag);
    int seen;
    seen = 0;
    repeat (edges) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    checkEq(tag, seen, 0);
  endtask

  initial begin
    reset_n       = 1'b0;
    ctrl_div      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    checkEq("reset result", data_result, 32'd0);
    checkEq("reset exception", {31'd0, data_exception}, 32'd0);
    checkEq("reset rdy", {31'd0, data_resultRDY}, 32'd0);
`ifdef DIV_ITER_REMAINDER_EN
    checkEq("reset remainder", data_remainder, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(32'd100, 32'd7, 1'b1);
    checkOutput(34, "100/7");
    repeat (5) @(negedge clock);
    checkEq("100/7 held", data_result, 32'd14);

    applyStimulus(-32'sd100, 32'd7, 1'b1);
    checkOutput(34, "-100/7");

    applyStimulus(32'd7, -32'sd2, 1'b1);
    checkOutput(34, "7/-2");

    applyStimulus(-32'sd7, -32'sd2, 1'b1);
    checkOutput(34, "-7/-2");

    applyStimulus(32'd0, 32'd5, 1'b1);
    checkOutput(34, "0/5");

    applyStimulus(32'd5, 32'd0, 1'b1);
    checkOutput(1, "5/0");
    watchNoRdy(40, "5/0 no extra rdy");

    applyStimulus(32'd100, 32'd7, 1'b0);
    watchNoRdy(9, "abort no early rdy");
    applyStimulus(32'd81, 32'd9, 1'b1);
    checkOutput(34, "abort 81/9");

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    checkOutput(34, "min/-1");

    applyStimulus(32'd100, 32'd7, 1'b0);
    watchNoRdy(19, "pre-reset no rdy");
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checkEq("mid-op reset result", data_result, 32'd0);
    checkEq("mid-op reset exception", {31'd0, data_exception}, 32'd0);
    checkEq("mid-op reset rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    watchNoRdy(40, "post-reset no rdy");
    applyStimulus(32'd6, 32'd3, 1'b1);
    checkOutput(34, "6/3 after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter_32.md
DIV_ITER_32 -- requirements
Module: div_iter_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits; the iteration count equals WIDTH.
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port ctrl_div, input, 1: start strobe, sampled on each rising edge.
REQ-005 SHALL have port data_operandA, input, WIDTH: signed two's-complement dividend, captured when ctrl_div=1.
REQ-006 SHALL have port data_operandB, input, WIDTH: signed two's-complement divisor, captured when ctrl_div=1.
REQ-007 SHALL have port data_result, output, WIDTH: signed quotient, registered, held until the next start.
REQ-008 SHALL have port data_exception, output, 1: divide-by-zero or overflow flag, valid with data_resultRDY.
REQ-009 SHALL have port data_resultRDY, output, 1: one-cycle pulse marking data_result/data_exception valid.

Function
REQ-010 SHALL implement a restoring shift-subtract divider on operand magnitudes, with one quotient bit per cycle.
REQ-011 SHALL use states IDLE, RUN, FIXUP, DONE; IDLE->RUN on ctrl_div=1 with a nonzero divisor, RUN->FIXUP after WIDTH cycles, FIXUP->DONE, DONE->IDLE.
REQ-012 SHALL assert data_resultRDY exactly WIDTH+2 rising edges after the edge that sampled ctrl_div (34 for WIDTH=32), for exactly one cycle.
REQ-013 SHALL truncate the quotient toward zero; the quotient is negated when the operand signs differ.
REQ-014 SHALL, on divisor=0, go IDLE->DONE, set data_result=0 and data_exception=1, and pulse RDY one edge after start.
REQ-015 SHALL, for dividend=most-negative and divisor=-1, return data_result=most-negative value with data_exception=1 at the normal latency.
REQ-016 SHALL, on ctrl_div=1 in any state, abort the current operation, capture the new operands, and restart the latency count; the aborted result is never signalled.
REQ-017 SHALL keep data_result and data_exception stable between RDY pulses.
REQ-018 SHALL compute all magnitude and subtract arithmetic at WIDTH+1 bits so that |most-negative| is representable.

Reset
REQ-019 SHALL, while reset_n=0, force the state to IDLE, data_result to 0, data_exception to 0, data_resultRDY to 0, and clear all internal registers.
REQ-020 SHALL, on reset asserted mid-operation, discard the operation with no RDY pulse; the first start after release behaves per REQ-012.

Configuration
REQ-021 SHALL recognise the macro DIV_ITER_REMAINDER_EN; when defined, an output data_remainder of WIDTH bits is added.
REQ-022 SHALL, with DIV_ITER_REMAINDER_EN, make the remainder carry the dividend's sign, satisfy A = Q*B + R, equal 0 on divide-by-zero, and reset to 0.
REQ-023 SHALL, without DIV_ITER_REMAINDER_EN, have no data_remainder port and no remainder sign-fixup logic.

Structure
REQ-024 SHALL take the state enumeration and the default WIDTH constant from shared package div_pkg.
REQ-025 SHALL place one restoring step (trial subtract, select partial remainder, produce quotient bit) in combinational sub-module div_step, instantiated once.

Verification
REQ-026 SHALL cover: A=100, B=7 -> result=14, exception=0, RDY at edge 34, remainder=2 when enabled.
REQ-027 SHALL cover: A=-100, B=7 -> result=0xFFFFFFF2, exception=0, remainder=0xFFFFFFFE when enabled.
REQ-028 SHALL cover: A=5, B=0 -> result=0, exception=1, RDY one edge after start, no further RDY.
REQ-029 SHALL cover: A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1 at edge 34.
REQ-030 SHALL cover: start 100/7, then start 81/9 at edge 10 -> single RDY at edge 44 with result=9.
REQ-031 SHALL cover: start 100/7, reset_n low at edge 20 -> outputs 0 immediately, no RDY; then start 6/3 -> result=2 at edge 34.
